fifo_pack_8to128: RTL and testbench
===================================

Name: fifo_pack_8to128

Overview:
Synchronous width-converting FIFO, the opposite direction of the existing 128-in/8-out unpacking FIFO.
- Accepts 8-bit bytes on the write side and packs every 16 bytes into one 128-bit word.
- Offers complete words only on the read side, with full/empty/almost flags.
- Sits between byte-serial producers and the 128-bit datapath; shares the team's f_interface-style flag semantics.

Parameters:
DEPTH, 16, number of 128-bit word entries; power of 2, >= 4
ALM_FULL_TH, 2, o_alm_full asserted when word_count >= DEPTH - ALM_FULL_TH
ALM_EMPTY_TH, 2, o_alm_empty asserted when word_count <= ALM_EMPTY_TH

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-low reset
i_wren  input  1  byte write request
i_wdata  input  8  write byte
i_rden  input  1  word read request
o_rdata  output  128  read word, registered
o_full  output  1  no byte can be accepted this cycle
o_empty  output  1  no complete word stored
o_alm_full  output  1  word-count threshold flag
o_alm_empty  output  1  word-count threshold flag
o_wr_err  output  1  one-cycle pulse: i_wren while o_full (byte dropped)
o_rd_err  output  1  one-cycle pulse: i_rden while o_empty (no pop)

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low. When reset is low at posedge clk:
  - byte_cnt, word_count, wr_ptr, rd_ptr and o_rdata all go to 0.
  - o_empty=1, o_alm_empty=1; o_full, o_alm_full, o_wr_err and o_rd_err go to 0.
  - A partially assembled word is discarded.
  - Reset mid-operation discards all contents; no read or write in a reset cycle takes effect.
- Write accept: wr_acc = i_wren && !o_full.
  - An accepted byte goes to lane byte_cnt (bits [8*byte_cnt+7 : 8*byte_cnt]); the first byte lands in [7:0] (little-endian).
  - byte_cnt increments and wraps from 15 to 0.
  - On the accept with byte_cnt==15, the assembled word (with this byte in [127:120]) is committed to the store at wr_ptr, wr_ptr increments (wraps at DEPTH), and word_count increments.
- Read accept: rd_acc = i_rden && !o_empty.
  - The store entry at rd_ptr is loaded into o_rdata at that edge, so data is visible the cycle after i_rden (1-cycle latency).
  - rd_ptr increments (wraps at DEPTH) and word_count decrements.
  - o_rdata holds its value when no read is accepted.
- Flags are combinational from registered state only; a same-cycle read never frees space for a same-cycle write.
  - o_empty = (word_count==0). A partial word never makes o_empty low.
  - o_full = (word_count==DEPTH) && (byte_cnt==15). While word_count==DEPTH, up to 15 bytes may still be assembled.
  - o_alm_full and o_alm_empty follow the thresholds above, on word_count only.
- Simultaneous commit and read: word_count is unchanged; pointers advance independently.
- Errors: o_wr_err and o_rd_err are registered, high for exactly the one cycle after the offending request. A rejected request changes no state.
- Widths: word_count is $clog2(DEPTH)+1 bits; the pointers are $clog2(DEPTH) bits; byte_cnt is 4 bits.
- No overflow or underflow of the counters is possible; an assertion checks word_count <= DEPTH.

Decomposition:
- Package fifo_pkg holds BYTE_W=8, WORD_W=128, BYTES_PER_WORD=16, and BCNT_W=4.
- One sub-module, fifo_word_store: DEPTH x 128 register array with write port (we, waddr, wdata) and registered read port (re, raddr, rdata).
- The top level keeps the byte assembler, the pointers/count, and the flags/errors.

Test Plan:
- Reset, then write bytes 0x00..0x0F on 16 consecutive cycles -> o_empty falls the cycle after the 16th write. One i_rden -> o_rdata = 0x0F0E0D0C0B0A09080706050403020100 one cycle later; o_empty returns to 1.
- Write 15 bytes only -> o_empty stays 1, i_rden gives o_rd_err=1 for one cycle, o_rdata stays 0.
- DEPTH=16: write 256 bytes -> o_alm_full rises when word_count reaches 14. Then 15 more bytes -> o_full=1. The next write gives o_wr_err=1, and state is unchanged on read-back.
- Full store with a simultaneous i_wren/i_rden -> only the read is accepted (write dropped, o_wr_err=1); word_count goes 16->15.
- Steady byte stream with a read every 16th cycle, run for 3*DEPTH words -> pointers wrap, every word matches the scoreboard in order, and the o_alm_empty threshold at word_count=2 is exercised.
- Assert reset (low) after 8 words plus 5 bytes -> the next cycle shows o_empty=1 and o_rdata=0. Subsequent 16 bytes form a fresh word starting at lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared widths and lane helper for the 8-to-128 packing FIFO.
package fifo_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 128;
  localparam int BYTES_PER_WORD = 16;
  localparam int BCNT_W         = 4;

  localparam logic [BCNT_W-1:0] LAST_LANE = 4'(BYTES_PER_WORD - 1);

  function automatic logic [WORD_W-1:0] put_lane(
    input logic [WORD_W-1:0] word,
    input logic [BCNT_W-1:0] lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] w_word;
    w_word = word;
    w_word[BYTE_W*lane +: BYTE_W] = data;
    return w_word;
  endfunction

endpackage

// File: rtl/fifo_pack_8to128_chk.sv
// Occupancy invariant for the packing FIFO word counter.
module fifo_pack_8to128_chk #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic          clk,
  input logic          reset,
  input logic [CW-1:0] i_word_cnt
);

  a_word_cnt_bound: assert property (@(posedge clk) disable iff (!reset)
    i_word_cnt <= CW'(DEPTH));

endmodule

// File: rtl/fifo_word_store.sv
// DEPTH x 128-bit register array with one write port and a registered read port.
module fifo_word_store
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WORD_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Entries carry no reset; validity is tracked by the owner's pointers.
  always_ff @(posedge clk) begin
    if (reset && i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_pack_8to128.sv
// Byte-in / 128-bit-word-out FIFO: assembles 16 little-endian bytes per word.
module fifo_pack_8to128
  import fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ALM_FULL_TH  = 2,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic              i_rden,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic              o_wr_err,
  output logic              o_rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - ALM_FULL_TH);
  localparam logic [CW-1:0] CNT_AEMPT = CW'(ALM_EMPTY_TH);

  logic [BCNT_W-1:0] r_byte_cnt;
  logic [WORD_W-1:0] r_asm;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_word_cnt;
  logic              r_wr_err;
  logic              r_rd_err;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_last_lane;
  logic              w_commit;
  logic [WORD_W-1:0] w_commit_word;

  assign w_empty       = (r_word_cnt == '0);
  assign w_full        = (r_word_cnt == CNT_DEPTH) && (r_byte_cnt == LAST_LANE);
  assign w_wr_acc      = i_wren && !w_full;
  assign w_rd_acc      = i_rden && !w_empty;
  assign w_last_lane   = (r_byte_cnt == LAST_LANE);
  assign w_commit      = w_wr_acc && w_last_lane;
  assign w_commit_word = put_lane(r_asm, r_byte_cnt, i_wdata);

  // Flags look only at registered state, so a read never makes room for a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_word_cnt <= '0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
        r_asm      <= w_last_lane ? '0 : w_commit_word;
      end
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_commit, w_rd_acc})
        2'b10:   r_word_cnt <= r_word_cnt + CW'(1);
        2'b01:   r_word_cnt <= r_word_cnt - CW'(1);
        default: r_word_cnt <= r_word_cnt;
      endcase
      r_wr_err <= i_wren && w_full;
      r_rd_err <= i_rden && w_empty;
    end
  end

  fifo_word_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_commit),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_commit_word),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_rdata)
  );

  fifo_pack_8to128_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .i_word_cnt (r_word_cnt)
  );

  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_alm_full  = (r_word_cnt >= CNT_AFULL);
  assign o_alm_empty = (r_word_cnt <= CNT_AEMPT);
  assign o_wr_err    = r_wr_err;
  assign o_rd_err    = r_rd_err;

endmodule

// File: tb/tb_fifo_pack_8to128.sv
// Scoreboard bench for fifo_pack_8to128: directed byte streams, monitor-checked words.
module tb_fifo_pack_8to128;

  localparam int DEPTH = 16;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         i_wren  = 1'b0;
  logic [7:0]   i_wdata = 8'h00;
  logic         i_rden  = 1'b0;
  logic [127:0] o_rdata;
  logic         o_full, o_empty, o_alm_full, o_alm_empty, o_wr_err, o_rd_err;

  always #5 clk = ~clk;

  fifo_pack_8to128 #(
    .DEPTH        (DEPTH),
    .ALM_FULL_TH  (2),
    .ALM_EMPTY_TH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_wren      (i_wren),
    .i_wdata     (i_wdata),
    .i_rden      (i_rden),
    .o_rdata     (o_rdata),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_wr_err    (o_wr_err),
    .o_rd_err    (o_rd_err)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rd_q[$];
  logic [127:0] m_asm      = '0;
  int           m_bytes    = 0;
  logic         exp_wr_err = 1'b0;
  logic         exp_rd_err = 1'b0;
  logic [127:0] m_last     = '0;
  logic         mon_vld    = 1'b0;
  logic         mon_rst    = 1'b0;
  logic         mon_en     = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_flags();
    int wc;
    wc = exp_q.size();
    chk("empty",     o_empty,     wc == 0);
    chk("full",      o_full,      (wc == DEPTH) && (m_bytes == 15));
    chk("alm_full",  o_alm_full,  wc >= DEPTH - 2);
    chk("alm_empty", o_alm_empty, wc <= 2);
    chk("wr_err",    o_wr_err,    exp_wr_err);
    chk("rd_err",    o_rd_err,    exp_rd_err);
  endtask

  // One clock of stimulus, driven at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
    logic full, empty;
    full  = (exp_q.size() == DEPTH) && (m_bytes == 15);
    empty = (exp_q.size() == 0);
    i_wren  = wr;
    i_wdata = d;
    i_rden  = rd;
    exp_wr_err = wr && full;
    exp_rd_err = rd && empty;
    if (rd && !empty) rd_q.push_back(exp_q.pop_front());
    if (wr && !full) begin
      m_asm[8*m_bytes +: 8] = d;
      if (m_bytes == 15) begin
        exp_q.push_back(m_asm);
        m_asm   = '0;
        m_bytes = 0;
      end else begin
        m_bytes++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    i_wren = 1'b0;
    i_rden = 1'b0;
    check_flags();
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    i_wren  = 1'b1;
    i_wdata = 8'hEE;
    i_rden  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    i_wren = 1'b0;
    i_rden = 1'b0;
    exp_q.delete();
    m_asm      = '0;
    m_bytes    = 0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    check_flags();
  endtask

  // Monitor: a word is presented the cycle after an accepted read.
  always @(posedge clk) begin
    mon_vld <= reset && i_rden && !o_empty;
    mon_rst <= !reset;
  end

  always @(negedge clk) begin
    if (mon_rst) begin
      m_last = '0;
      mon_en = 1'b1;
      chk("rdata_after_reset", o_rdata, 128'h0);
    end else if (mon_en) begin
      if (mon_vld) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got %h expected no word", o_rdata);
        end else begin
          m_last = rd_q.pop_front();
          chk("read_word", o_rdata, m_last);
        end
      end else begin
        chk("rdata_hold", o_rdata, m_last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);

    // Basic 16-byte word and read-back
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("t1_not_empty", o_empty, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_word", o_rdata, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_empty_again", o_empty, 1'b1);

    // Partial word stays invisible
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("t2_still_empty", o_empty, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t2_rd_err", o_rd_err, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_rd_err_pulse", o_rd_err, 1'b0);
    chk("t2_rdata_zero", o_rdata, 128'h0);

    // Fill to full, overflow attempt
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 8'(i * 7 + 3), 1'b0);
      if (i == 13*16 - 1) chk("t3_alm_full_at_13", o_alm_full, 1'b0);
      if (i == 14*16 - 1) chk("t3_alm_full_at_14", o_alm_full, 1'b1);
    end
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    chk("t3_full", o_full, 1'b1);
    cyc(1'b1, 8'hCC, 1'b0);
    chk("t3_wr_err", o_wr_err, 1'b1);
    chk("t3_still_full", o_full, 1'b1);

    // Simultaneous write/read when full: only the read lands
    cyc(1'b1, 8'hDD, 1'b1);
    chk("t4_wr_err", o_wr_err, 1'b1);
    chk("t4_not_full", o_full, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hAB, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t4_drained", o_empty, 1'b1);

    // Steady stream, pointer wrap, alm_empty toggling between 2 and 3
    do_reset();
    for (int i = 0; i < 48*16; i++) begin
      cyc(1'b1, 8'(i) ^ 8'h5A, (i % 16 == 7) && (i >= 55));
    end
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() != 0) cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Reset mid-operation discards words and the partial word
    do_reset();
    for (int i = 0; i < 8*16 + 5; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    do_reset();
    chk("t6_empty", o_empty, 1'b1);
    chk("t6_rdata_zero", o_rdata, 128'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_fresh_word", o_rdata, 128'h8F8E8D8C8B8A89888786858483828180);
    cyc(1'b0, 8'h00, 1'b0);

    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", rd_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
